csa_mul_tree_pipe: RTL
======================

Name: csa_mul_tree_pipe

Overview:
- Parametrised, pipelined signed/unsigned WIDTH x WIDTH multiplier core for the Posit FMA datapath.
- Generates radix-4 Booth partial products internally and reduces them with a Wallace tree of 3:2 compressors. An optional 2*WIDTH addend row is folded into the tree for fused multiply-add.
- Output is left in carry-save form (two rows) for the downstream final adder / alignment stage.
- Supersedes the fixed 8x8 combinational reduction tree: adds width and pipeline parametrisation, per-transaction signedness, addend injection and a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32, even.
- STAGES, 2, register stages from input acceptance to output; legal range 1..4.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1: a, b two's complement; 0: unsigned.
- acc_en  in  1  1: add c into the result.
- c  in  2*WIDTH  addend, taken as a raw 2*WIDTH pattern.
- out_valid  out  1  pp0/pp1 hold a valid result.
- out_ready  in  1  downstream accepts the result.
- pp0  out  2*WIDTH  carry-save sum row.
- pp1  out  2*WIDTH  carry-save carry row.

Behaviour:
- Reset: the clock is clk and the reset is rst_n, asynchronous and active-low.
  - rst_n low clears every stage valid bit.
  - Output values during reset: out_valid=0, pp0=0, pp1=0.
  - in_ready becomes 1 once out_valid is 0.
  - Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- Arithmetic contract: (pp0 + pp1) mod 2^(2W) = (A*B + (acc_en ? c : 0)) mod 2^(2W).
  - A = is_signed ? signed(a) : unsigned(a); B likewise.
  - Only the sum of the two rows is specified. Individual row values are implementation-defined, apart from being 0 at reset.
- Unsigned mode: operands are extended to WIDTH+2 bits before Booth recoding, giving WIDTH/2+1 partial-product rows. Signed mode gives WIDTH/2 rows.
- Booth negation +1 bits and sign-extension constants are injected as tree rows or carry-ins. No final carry-propagate adder is placed inside the block.
- All compressor carries beyond bit 2W-1 are dropped (modulo-2^(2W) arithmetic).
- Pipeline:
  - STAGES register slices, each holding a valid bit plus intermediate rows.
  - Slice 1 captures at least the Booth rows. The last slice drives pp0/pp1 directly from flops.
  - Reduction levels are distributed as evenly as possible across the slices.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
  - When advance=1 every slice shifts one step. Slice 1 loads in_valid, and loads operand data only when in_valid=1.
  - When advance=0 all slices hold; pp0/pp1/out_valid stay stable.
  - Operands are sampled only on a cycle where in_valid & in_ready = 1.
  - Latency is STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 per cycle.
  - Bubbles are not collapsed: a stall freezes the entire pipe, including empty slices.
- Transfer out happens on out_valid & out_ready. With no new input, out_valid drops on the following advance.
- Simultaneous output transfer and input acceptance in the same cycle is legal and loses nothing.
- in_valid may drop without acceptance; no state changes in that case.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Signed extremes: a=0x80, b=0x80, is_signed=1, acc_en=0 -> pp0+pp1 = 0x4000 two cycles after acceptance.
- Mixed sign: a=0x7F, b=0xFF, signed -> sum 0xFF81. Same operands unsigned -> sum 0x7E81. Also a=0xFF, b=0xFF unsigned -> 0xFE01.
- FMA addend: a=3, b=5, signed, acc_en=1, c=0xFFEC -> sum 0xFFFB. acc_en=0 with the same c -> 0x000F.
- Backpressure: stream 4 back-to-back ops while out_ready=0 from cycle 3 to cycle 6.
  - in_ready is 0 whenever out_valid=1 and out_ready=0.
  - pp0/pp1 are stable during the stall.
  - All 4 results arrive in order with correct sums, none lost or duplicated.
- Reset mid-operation: accept 2 ops, assert rst_n low for 1 cycle before completion.
  - out_valid=0, pp0=pp1=0 immediately (asynchronous).
  - No result appears afterwards.
  - A new op accepted after reset completes in STAGES cycles.
- Random sweep: 10k random a, b, c, mode values for WIDTH in {4, 8, 16} and STAGES in {1, 4}, with random out_ready -> every sum matches the reference model, and latency equals STAGES plus stall cycles.

Source files
------------

// File: rtl/csa_mul_tree_pipe.sv
// csa_mul_tree_pipe: pipelined radix-4 Booth multiplier with a Wallace 3:2 tree.
// The product plus an optional addend leaves the block in carry-save form on pp0/pp1.
module csa_mul_tree_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic                 acc_en,
    input  logic [2*WIDTH-1:0]   c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   pp0,
    output logic [2*WIDTH-1:0]   pp1
);

    localparam int W2   = 2 * WIDTH;
    localparam int NB   = WIDTH / 2 + 1;
    localparam int NROW = NB + 2;

    typedef logic [NROW-1:0][W2-1:0] rows_t;

    function automatic int num_levels();
        int n;
        int l;
        n = NROW;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NLV = num_levels();

    // Rows 0..NB-1 are Booth rows, NB holds the negation +1 bits, NB+1 the addend.
    // Operands are always extended by two bits; in signed mode the top digit is zero.
    function automatic rows_t booth_rows(
        input logic [WIDTH-1:0] a_i,
        input logic [WIDTH-1:0] b_i,
        input logic             sgn,
        input logic             acc,
        input logic [W2-1:0]    c_i
    );
        rows_t          r;
        logic [W2-1:0]  aw;
        logic [W2-1:0]  mag;
        logic [WIDTH+2:0] bx;
        logic [2:0]     trip;
        logic           one;
        logic           two;
        logic           neg;
        r   = '0;
        aw  = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
        bx  = {{2{sgn & b_i[WIDTH-1]}}, b_i, 1'b0};
        for (int i = 0; i < NB; i++) begin
            trip = bx[2*i +: 3];
            one  = trip[1] ^ trip[0];
            two  = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
            neg  = trip[2];
            mag  = one ? aw : (two ? (aw << 1) : '0);
            r[i] = (neg ? ~mag : mag) << (2 * i);
            r[NB][2*i] = neg;
        end
        r[NB+1] = acc ? c_i : '0;
        return r;
    endfunction

    // One Wallace level: each full group of three rows becomes sum + shifted carry.
    function automatic rows_t csa_level(input rows_t r, input int n);
        rows_t         o;
        int            g;
        logic [W2-1:0] x;
        logic [W2-1:0] y;
        logic [W2-1:0] z;
        o = '0;
        g = n / 3;
        for (int i = 0; i < NROW / 3; i++) begin
            if (i < g) begin
                x = r[3*i];
                y = r[3*i+1];
                z = r[3*i+2];
                o[2*i]   = x ^ y ^ z;
                o[2*i+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (j < n % 3) o[2*g+j] = r[3*g+j];
        end
        return o;
    endfunction

    function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
        rows_t t;
        int    n;
        t = r;
        n = NROW;
        for (int l = 0; l < NLV; l++) begin
            if (l >= lo && l < hi) t = csa_level(t, n);
            n = 2 * (n / 3) + n % 3;
        end
        return t;
    endfunction

    function automatic logic [2*W2-1:0] final_rows(
        input rows_t r,
        input int    lo,
        input int    hi
    );
        rows_t t;
        t = reduce(r, lo, hi);
        return {t[1], t[0]};
    endfunction

    logic  advance;
    logic  vld_s [STAGES+1];
    rows_t row_s [STAGES];

    assign advance   = !vld_s[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_s[STAGES];
    assign vld_s[0]  = in_valid;
    assign row_s[0]  = booth_rows(a, b, is_signed, acc_en, c);

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int LO = (k * NLV) / STAGES;
        localparam int HI = ((k + 1) * NLV) / STAGES;

        logic vld_d;
        logic vld_q;
        logic load;

        // Only the first slice gates its data on in_valid; later slices shift freely.
        assign load = (k > 0) ? advance : (advance && in_valid);

        always_comb begin
            vld_d = vld_q;
            if (advance) vld_d = vld_s[k];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_q <= 1'b0;
            else        vld_q <= vld_d;
        end

        assign vld_s[k+1] = vld_q;

        if (k < STAGES - 1) begin : g_mid
            rows_t rows_d;
            rows_t rows_q;

            always_comb begin
                rows_d = rows_q;
                if (load) rows_d = reduce(row_s[k], LO, HI);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rows_q <= '0;
                else        rows_q <= rows_d;
            end

            assign row_s[k+1] = rows_q;
        end else begin : g_tail
            logic [W2-1:0] pp0_d;
            logic [W2-1:0] pp1_d;
            logic [W2-1:0] pp0_q;
            logic [W2-1:0] pp1_q;

            always_comb begin
                pp0_d = pp0_q;
                pp1_d = pp1_q;
                if (load) {pp1_d, pp0_d} = final_rows(row_s[k], LO, HI);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pp0_q <= '0;
                    pp1_q <= '0;
                end else begin
                    pp0_q <= pp0_d;
                    pp1_q <= pp1_d;
                end
            end

            assign pp0 = pp0_q;
            assign pp1 = pp1_q;
        end
    end

endmodule
